// File: rtl/input_line_buffer_stream.sv
// Three-bank row buffer that streams 3-pixel vertical window columns to the PE array.
// Optional sequencing checker enabled by defining ILB_SEQ_CHECK_EN.
module input_line_buffer_stream #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_IMAGE_SIZE = 128,
  parameter int ADDR_WIDTH     = 7
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [7:0]            IMAGE_SIZE,
  input  logic                  Stream_first_row,
  input  logic                  Stream_mid_row,
  input  logic                  Stream_last_row,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] col_top,
  output logic [DATA_WIDTH-1:0] col_mid,
  output logic [DATA_WIDTH-1:0] col_bot,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic                  col_first,
  output logic                  col_last,
  output logic                  Done_1row,
  output logic                  Input_line_buffer_IDLE,
  output logic                  seq_err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {M_NONE, M_FIRST, M_MID, M_LAST} mode_t;

  state_t                state;
  mode_t                 mode;
  logic [1:0]            top_sel, mid_sel, bot_sel;
  logic [ADDR_WIDTH-1:0] fill_col, col_cnt;
  logic                  fill_second;
  logic [DATA_WIDTH-1:0] bank [0:2][0:MAX_IMAGE_SIZE-1];

  logic [7:0] last_idx;
  logic [1:0] fill_bank;
  logic       fill_beat, fill_row_end, col_fire, cmd_ok;

  assign last_idx     = IMAGE_SIZE - 8'd1;
  assign fill_bank    = fill_second ? mid_sel : top_sel;
  assign fill_beat    = (state == S_FILL) && s_axis_tvalid;
  assign fill_row_end = (8'(fill_col) == last_idx);
  assign col_fire     = (state == S_EMIT) && col_ready;

  assign s_axis_tready          = (state == S_FILL);
  assign col_valid              = (state == S_EMIT);
  assign col_first              = (state == S_EMIT) && (col_cnt == '0);
  assign col_last               = (state == S_EMIT) && (8'(col_cnt) == last_idx);
  assign Done_1row              = (state == S_DONE);
  assign Input_line_buffer_IDLE = (state == S_IDLE);

`ifdef ILB_SEQ_CHECK_EN
  logic [1:0] rows_ready;
  logic       seq_err_q;

  // mid/last are only legal once a first has primed two rows; illegal ones are dropped
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rows_ready <= 2'd0;
      seq_err_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (Stream_first_row)
        rows_ready <= 2'd2;
      else if ((Stream_mid_row || Stream_last_row) && rows_ready != 2'd2)
        seq_err_q <= 1'b1;
    end else if (state == S_DONE && mode == M_LAST) begin
      rows_ready <= 2'd0;
    end
  end

  assign cmd_ok  = (rows_ready == 2'd2);
  assign seq_err = seq_err_q;
`else
  assign cmd_ok  = 1'b1;
  assign seq_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (aresetn && fill_beat)
      bank[fill_bank][fill_col] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      mode        <= M_NONE;
      top_sel     <= 2'd0;
      mid_sel     <= 2'd1;
      bot_sel     <= 2'd2;
      fill_col    <= '0;
      col_cnt     <= '0;
      fill_second <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fill_col    <= '0;
          fill_second <= 1'b0;
          if (Stream_first_row) begin
            mode  <= M_FIRST;
            state <= S_FILL;
          end else if (Stream_mid_row) begin
            if (cmd_ok) begin
              mode  <= M_MID;
              state <= S_FILL;
            end
          end else if (Stream_last_row && cmd_ok) begin
            mode  <= M_LAST;
            state <= S_EMIT;
          end
        end
        S_FILL: begin
          if (s_axis_tvalid) begin
            fill_col <= fill_row_end ? '0 : fill_col + 1'b1;
            if (fill_row_end) begin
              if (mode == M_FIRST && !fill_second) begin
                fill_second <= 1'b1;
              end else begin
                state <= S_EMIT;
                // The freshly filled (oldest) bank becomes the bottom row
                if (mode == M_MID) begin
                  top_sel <= mid_sel;
                  mid_sel <= bot_sel;
                  bot_sel <= top_sel;
                end
              end
            end
          end
        end
        S_EMIT: begin
          if (col_fire) begin
            if (col_last) begin
              state <= S_DONE;
              // Park the free bank in top_sel so the next mid fills it
              if (mode == M_FIRST) begin
                top_sel <= bot_sel;
                mid_sel <= top_sel;
                bot_sel <= mid_sel;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          col_cnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    col_top = '0;
    col_mid = '0;
    col_bot = '0;
    if (state == S_EMIT) begin
      case (mode)
        M_FIRST: begin
          col_mid = bank[top_sel][col_cnt];
          col_bot = bank[mid_sel][col_cnt];
        end
        M_MID: begin
          col_top = bank[top_sel][col_cnt];
          col_mid = bank[mid_sel][col_cnt];
          col_bot = bank[bot_sel][col_cnt];
        end
        M_LAST: begin
          col_top = bank[mid_sel][col_cnt];
          col_mid = bank[bot_sel][col_cnt];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_line_buffer_stream.sv
// Scoreboard bench for input_line_buffer_stream at IMAGE_SIZE=4; expected columns are queued
// when a command is issued and checked by a monitor. Honours ILB_SEQ_CHECK_EN.
module tb_input_line_buffer_stream;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic [7:0]    IMAGE_SIZE;
  logic          Stream_first_row, Stream_mid_row, Stream_last_row;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] col_top, col_mid, col_bot;
  logic          col_valid, col_ready, col_first, col_last;
  logic          Done_1row, Input_line_buffer_IDLE, seq_err;

  input_line_buffer_stream #(.DATA_WIDTH(DW), .MAX_IMAGE_SIZE(128), .ADDR_WIDTH(7)) dut (
    .clk(clk), .aresetn(aresetn), .IMAGE_SIZE(IMAGE_SIZE),
    .Stream_first_row(Stream_first_row), .Stream_mid_row(Stream_mid_row),
    .Stream_last_row(Stream_last_row),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .col_valid(col_valid), .col_ready(col_ready), .col_first(col_first), .col_last(col_last),
    .Done_1row(Done_1row), .Input_line_buffer_IDLE(Input_line_buffer_IDLE), .seq_err(seq_err)
  );

  typedef struct packed {
    logic [DW-1:0] t, m, b;
    logic          f, l;
  } col_t;

  col_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   hs_cnt   = 0;
  logic last_hs_prev = 1'b0;
  logic done_prev    = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Base 0 means a zero-padded row; otherwise the row holds base, base+1, ...
  task automatic push_cols(input int t, input int m, input int b);
    col_t c;
    for (int i = 0; i < 4; i++) begin
      c.t = (t == 0) ? '0 : DW'(t + i);
      c.m = (m == 0) ? '0 : DW'(m + i);
      c.b = (b == 0) ? '0 : DW'(b + i);
      c.f = (i == 0);
      c.l = (i == 3);
      exp_q.push_back(c);
    end
  endtask

  task automatic run_monitor();
    col_t act, e;
    forever begin
      @(negedge clk);
      if (last_hs_prev || Done_1row) checkOutput("done_timing", 64'(Done_1row), 64'(last_hs_prev));
      if (Done_1row) begin
        done_cnt++;
        checkOutput("idle_in_done", 64'(Input_line_buffer_IDLE), 64'd0);
      end
      if (done_prev) checkOutput("idle_after_done", 64'(Input_line_buffer_IDLE), 64'd1);
      done_prev    = Done_1row;
      last_hs_prev = 1'b0;
      if (col_valid) begin
        act = {col_top, col_mid, col_bot, col_first, col_last};
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_col", 64'(col_valid), 64'd0);
        end else begin
          e = exp_q[0];
          checkOutput(col_ready ? "col_handshake" : "col_hold", 64'(act), 64'(e));
          if (col_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            last_hs_prev = e.l;
          end
        end
      end
    end
  endtask

  // kind bits: [0]=first, [1]=mid, [2]=last; called at posedge+1
  task automatic applyStimulus(input logic [2:0] kind);
    Stream_first_row = kind[0];
    Stream_mid_row   = kind[1];
    Stream_last_row  = kind[2];
    @(posedge clk); #1;
    Stream_first_row = 1'b0;
    Stream_mid_row   = 1'b0;
    Stream_last_row  = 1'b0;
  endtask

  task automatic stream_pixels(input int first_val, input int n);
    int   sent  = 0;
    int   guard = 0;
    logic ok;
    while (sent < n && guard < 200) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(first_val + sent);
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk); #1;
      if (ok) sent++;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    checkOutput("beats_accepted", 64'(sent), 64'(n));
  endtask

  task automatic check_valid_next(input string name);
    @(negedge clk);
    checkOutput(name, 64'(col_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target, input bit toggle, output bit tready_seen);
    int         guard = 0;
    logic [3:0] pat   = 4'b1001;
    tready_seen = 1'b0;
    while (done_cnt < target && guard < 100) begin
      if (toggle) col_ready = pat[guard % 4];
      @(posedge clk); #1;
      guard++;
      tready_seen |= s_axis_tready;
    end
    col_ready = 1'b1;
    checkOutput("done_count", 64'(done_cnt), 64'(target));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    aresetn = 1'b0; IMAGE_SIZE = 8'd4;
    Stream_first_row = 1'b0; Stream_mid_row = 1'b0; Stream_last_row = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; col_ready = 1'b1;
    fork run_monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idle",    64'(Input_line_buffer_IDLE), 64'd1);
    checkOutput("rst_tready",  64'(s_axis_tready), 64'd0);
    checkOutput("rst_valid",   64'(col_valid), 64'd0);
    checkOutput("rst_done",    64'(Done_1row), 64'd0);
    checkOutput("rst_seq_err", 64'(seq_err), 64'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // first: rows 1..4 / 5..8 with zero top padding
    push_cols(0, 1, 5);
    applyStimulus(3'b001);
    stream_pixels(1, 8);
    check_valid_next("first_fill_latency");
    wait_done(1, 1'b0, seen);

    // mid: row 9..12 completes the window
    push_cols(1, 5, 9);
    applyStimulus(3'b010);
    stream_pixels(9, 4);
    check_valid_next("mid_fill_latency");
    wait_done(2, 1'b0, seen);

    // last: no input beats, bottom zero padding
    push_cols(5, 9, 0);
    applyStimulus(3'b100);
    @(negedge clk);
    checkOutput("last_latency", 64'(col_valid), 64'd1);
    @(posedge clk); #1;
    wait_done(3, 1'b0, seen);
    checkOutput("tready_during_last", 64'(seen), 64'd0);

    // col_ready backpressure 1,0,0,1
    hs_cnt = 0;
    push_cols(0, 21, 25);
    applyStimulus(3'b001);
    stream_pixels(21, 8);
    check_valid_next("bp_fill_latency");
    wait_done(4, 1'b1, seen);
    checkOutput("bp_handshakes", 64'(hs_cnt), 64'd4);

    // first+last together: first wins; last during emit ignored
    push_cols(0, 31, 35);
    applyStimulus(3'b101);
    stream_pixels(31, 8);
    check_valid_next("prio_fill_latency");
    col_ready = 1'b0;
    applyStimulus(3'b100);
    col_ready = 1'b1;
    wait_done(5, 1'b0, seen);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ignored_last_idle", 64'(Input_line_buffer_IDLE), 64'd1);
    checkOutput("ignored_last_no_done", 64'(done_cnt), 64'd5);

    // reset after 3 of 8 fill beats
    applyStimulus(3'b001);
    stream_pixels(41, 3);
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_idle",   64'(Input_line_buffer_IDLE), 64'd1);
    checkOutput("abort_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("abort_done",   64'(Done_1row), 64'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    push_cols(0, 51, 55);
    applyStimulus(3'b001);
    stream_pixels(51, 8);
    check_valid_next("refill_latency");
    wait_done(6, 1'b0, seen);

    // mid straight after reset
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    checkOutput("rst2_seq_err", 64'(seq_err), 64'd0);
    @(posedge clk); #1;
`ifdef ILB_SEQ_CHECK_EN
    applyStimulus(3'b010);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(61);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= s_axis_tready;
    end
    s_axis_tvalid = 1'b0;
    checkOutput("seq_no_fill",  64'(seen), 64'd0);
    checkOutput("seq_err_set",  64'(seq_err), 64'd1);
    checkOutput("seq_idle",     64'(Input_line_buffer_IDLE), 64'd1);
    checkOutput("seq_no_done",  64'(done_cnt), 64'd6);
`else
    // banks after reset: 0=51..54, 1=55..58, 2=31..34; mid refills bank 0
    push_cols(55, 31, 61);
    applyStimulus(3'b010);
    stream_pixels(61, 4);
    check_valid_next("unchecked_mid_latency");
    wait_done(7, 1'b0, seen);
    checkOutput("seq_err_tied", 64'(seq_err), 64'd0);
`endif
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_line_buffer_stream.md
Name: input_line_buffer_stream

Overview:
- Responder side of the row-streaming command interface issued by the conv control unit.
- Accepts one-cycle Stream_first_row / Stream_mid_row / Stream_last_row commands.
- Pulls input-feature pixels from an AXI-Stream slave into three rotating row banks, then emits one 3-pixel vertical window column per handshake to the PE datapath.
- Top/bottom zero padding is inserted automatically. It reports completion with Done_1row and availability with Input_line_buffer_IDLE.

Parameters:
- DATA_WIDTH, 16, pixel width in bits.
- MAX_IMAGE_SIZE, 128, depth of each row bank.
- ADDR_WIDTH, 7, column index width; must satisfy 2^ADDR_WIDTH >= MAX_IMAGE_SIZE.

Ports:
- clk  in  1  system clock
- aresetn  in  1  synchronous active-low reset, sampled on rising clk edge
- IMAGE_SIZE  in  8  row length in pixels; legal values 4,8,16,32,64,128; held stable while not idle
- Stream_first_row  in  1  command pulse: load rows 0 and 1, emit output row 0
- Stream_mid_row  in  1  command pulse: load one new row, emit next output row
- Stream_last_row  in  1  command pulse: no load, emit final output row
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input pixel accept
- col_top  out  DATA_WIDTH  window column, upper row
- col_mid  out  DATA_WIDTH  window column, centre row
- col_bot  out  DATA_WIDTH  window column, lower row
- col_valid  out  1  column valid
- col_ready  in  1  PE accepts column
- col_first  out  1  high with column 0
- col_last  out  1  high with column IMAGE_SIZE-1
- Done_1row  out  1  one-cycle pulse after the last column is accepted
- Input_line_buffer_IDLE  out  1  high only in S_IDLE
- seq_err  out  1  sticky sequencing error (see Optional Feature)

Behaviour:
- Reset (aresetn=0 at clk edge):
  - State goes to S_IDLE; column and fill counters go to 0.
  - Bank selects: top_sel=0, mid_sel=1, bot_sel=2. Mode register is cleared.
  - All outputs are 0 except Input_line_buffer_IDLE=1. Bank contents are not cleared.
  - Reset mid-fill or mid-emit aborts immediately. No Done_1row is produced.
- States: S_IDLE, S_FILL, S_EMIT, S_DONE.
- S_IDLE:
  - Commands are sampled only here; commands in any other state are ignored.
  - Simultaneous commands resolve with priority first > mid > last.
  - first: mode=FIRST; fill target = bank top_sel then bank mid_sel; fill length 2*IMAGE_SIZE. Go to S_FILL.
  - mid: fill target = bank top_sel (the oldest row); fill length IMAGE_SIZE. Go to S_FILL.
  - last: go directly to S_EMIT.
- S_FILL:
  - s_axis_tready=1. Each tvalid&tready beat writes bank[target][fill_col], then fill_col increments.
  - At fill_col==IMAGE_SIZE-1 the count wraps to 0. In FIRST mode the target then switches to the second bank.
  - After the final beat, the next state is S_EMIT.
  - For mid, the rotation is committed on entering S_EMIT: top<=mid, mid<=bot, bot<=filled bank.
  - tvalid low stalls the fill with no timeout.
- S_EMIT:
  - col_valid=1. Column data is a combinational read at col_cnt.
  - FIRST: top=0, mid=bank[top_sel], bot=bank[mid_sel]. On entering S_DONE the selects rotate so that the next mid command fills the free bank.
  - MID: top=bank[top_sel], mid=bank[mid_sel], bot=bank[bot_sel].
  - LAST: top=bank[mid_sel], mid=bank[bot_sel], bot=0.
  - col_first = (col_cnt==0); col_last = (col_cnt==IMAGE_SIZE-1).
  - col_cnt advances only on col_valid&col_ready. Outputs hold stable while col_ready=0.
  - A handshake on col_last goes to S_DONE.
- S_DONE:
  - Done_1row=1 for exactly one cycle; IDLE=0 in this cycle.
  - col_cnt is cleared. Next state is S_IDLE, with IDLE=1 on the following cycle.
- Latency:
  - Command to first col_valid = fill beats + 1 cycle for first/mid.
  - Command to first col_valid = 1 cycle for last.
  - Last column handshake to Done_1row = 1 cycle.
- IMAGE_SIZE outside the legal set is undefined behaviour.

Optional Feature:
- Macro ILB_SEQ_CHECK_EN.
- Defined:
  - A 2-bit rows_ready counter tracks sequencing: first sets it to 2, and it is cleared after last.
  - A mid or last command with rows_ready<2 is discarded. The block stays in S_IDLE, no Done_1row is produced, and seq_err is set.
  - seq_err stays set until aresetn=0.
- Undefined: all commands are honoured regardless of history, and seq_err is tied 0.

Test Plan:
- IMAGE_SIZE=4, first, pixels 1..8 streamed back-to-back, col_ready=1 -> 4 columns (0,1,5),(0,2,6),(0,3,7),(0,4,8); col_first on column 0, col_last on column 3; Done_1row one cycle after the last column; IDLE returns the next cycle.
- Continue with mid and pixels 9..12 -> columns (1,5,9)..(4,8,12); then last with no input beats -> (5,9,0)..(8,12,0); s_axis_tready stays 0 throughout last.
- col_ready toggled 1,0,0,1 during emit -> column data and col_cnt held while low; exactly IMAGE_SIZE handshakes occur; one Done_1row.
- first and last asserted in the same cycle while idle -> only first executes; last issued during S_EMIT is ignored; no extra Done_1row.
- aresetn=0 mid-fill after 3 of 8 beats -> IDLE=1, tready=0 and Done_1row=0 next cycle; a fresh first then produces correct data.
- With ILB_SEQ_CHECK_EN, mid after reset -> seq_err=1, no fill, IDLE stays 1; without the macro, seq_err stays 0 and mid executes.
